// File: rtl/multi_edge_detector_if.sv
// Channel bundle for multi_edge_detector: raw inputs and controls in, debounced level, pulses and status out.
interface multi_edge_detector_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] signal;
    logic [WIDTH-1:0] enable;
    logic [WIDTH-1:0] rise_en;
    logic [WIDTH-1:0] fall_en;
    logic [WIDTH-1:0] clear;
    logic [WIDTH-1:0] filtered;
    logic [WIDTH-1:0] rising_edge;
    logic [WIDTH-1:0] falling_edge;
    logic [WIDTH-1:0] status;
    logic             irq;

    modport master (
        output signal, enable, rise_en, fall_en, clear,
        input  filtered, rising_edge, falling_edge, status, irq
    );

    modport slave (
        input  signal, enable, rise_en, fall_en, clear,
        output filtered, rising_edge, falling_edge, status, irq
    );
endinterface

// File: rtl/multi_edge_detector.sv
// Per-channel synchroniser + stable-count glitch filter with gated edge pulses and sticky status/IRQ.
// FILTERED and pulses appear SYNC_STAGES+FILTER_CYCLES edges after a stable input change; no backpressure.
module multi_edge_detector #(
    parameter int WIDTH         = 8,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    multi_edge_detector_if.slave  io_bus
);
    localparam logic [CNT_W-1:0] LP_CNT_LAST = CNT_W'(FILTER_CYCLES - 1);
    localparam logic [CNT_W-1:0] LP_CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [CNT_W-1:0] r_cnt  [WIDTH];
    logic [WIDTH-1:0] r_filtered;
    logic [WIDTH-1:0] r_rise;
    logic [WIDTH-1:0] r_fall;
    logic [WIDTH-1:0] r_status;

    logic [WIDTH-1:0] w_s;
    logic [WIDTH-1:0] w_accept;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    assign w_s = r_sync[SYNC_STAGES-1];

    // A channel's new level is accepted on the edge its counter has already seen FILTER_CYCLES-1 differing cycles.
    always_comb begin
        w_accept = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_accept[i] = (w_s[i] != r_filtered[i]) && (r_cnt[i] == LP_CNT_LAST);
        end
    end

    assign w_rise = w_accept &  w_s & io_bus.enable & io_bus.rise_en;
    assign w_fall = w_accept & ~w_s & io_bus.enable & io_bus.fall_en;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= '0;
            end
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            r_filtered <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
            r_status   <= '0;
        end else begin
            r_sync[0] <= io_bus.signal;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
            for (int i = 0; i < WIDTH; i++) begin
                if ((w_s[i] == r_filtered[i]) || w_accept[i]) begin
                    r_cnt[i] <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + LP_CNT_ONE;
                end
            end
            r_filtered <= r_filtered ^ w_accept;
            r_rise     <= w_rise;
            r_fall     <= w_fall;
            // Set from the registered pulse so a same-edge CLEAR loses to it.
            r_status   <= (r_status & ~io_bus.clear) | r_rise | r_fall;
        end
    end

    assign io_bus.filtered     = r_filtered;
    assign io_bus.rising_edge  = r_rise;
    assign io_bus.falling_edge = r_fall;
    assign io_bus.status       = r_status;
    assign io_bus.irq          = |r_status;
endmodule

// File: doc/multi_edge_detector.md
Name: multi_edge_detector

Overview:
- Parametrised, multi-channel successor to the single-bit edge detector.
- Each channel synchronises an asynchronous input and applies a stable-count glitch filter.
- Each channel produces one-cycle rising/falling pulses, gated per channel and per direction.
- Pulses also set sticky status bits that drive a single interrupt line. Sits between raw board I/O (buttons, switches, external strobes) and control logic or a CSR block.

Parameters:
- WIDTH, 8, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser flops per channel (>=2).
- FILTER_CYCLES, 4, consecutive cycles a synchronised value must differ from FILTERED before it is accepted (>=1; 1 = no filtering).
- CNT_W, 8, filter counter width; FILTER_CYCLES must be < 2**CNT_W.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  synchronous, active-high reset.
- SIGNAL  in  WIDTH  raw asynchronous inputs.
- ENABLE  in  WIDTH  per-channel pulse/status enable.
- RISE_EN  in  WIDTH  per-channel rising-edge detection enable.
- FALL_EN  in  WIDTH  per-channel falling-edge detection enable.
- CLEAR  in  WIDTH  per-channel sticky-status clear; 1-cycle or level.
- FILTERED  out  WIDTH  debounced, synchronised level.
- RISING_EDGE  out  WIDTH  1-cycle pulse on accepted 0->1.
- FALLING_EDGE  out  WIDTH  1-cycle pulse on accepted 1->0.
- STATUS  out  WIDTH  sticky "edge seen" flags.
- IRQ  out  1  OR-reduction of STATUS.

Behaviour:
- Reset: synchronous; sampled only at a rising CLK edge while RESET=1. It clears all synchroniser flops, filter counters, FILTERED, RISING_EDGE, FALLING_EDGE and STATUS to 0; IRQ=0. Reset mid-filter discards the partial count, and no pulse is produced for that transition.
- Synchroniser: SIGNAL[i] passes through SYNC_STAGES flops; the last stage is s[i].
- Filter counter, per channel, each cycle:
  - If s[i]==FILTERED[i], the counter clears to 0.
  - Else if counter==FILTER_CYCLES-1, FILTERED[i] <= s[i] and the counter clears.
  - Else the counter increments.
  - A glitch on s[i] shorter than FILTER_CYCLES cycles never changes FILTERED and produces no pulse.
  - A bounce that returns s[i] to FILTERED restarts the count from 0.
- Edge pulses:
  - RISING_EDGE[i] is registered and asserts in the same cycle FILTERED[i] goes 0->1, if ENABLE[i]&RISE_EN[i]. FALLING_EDGE[i] is the symmetric case for 1->0 with FALL_EN[i].
  - Pulse width is exactly 1 cycle. Rise and fall cannot both assert on one channel in one cycle; minimum spacing is FILTER_CYCLES cycles.
- Latency: count as edge 1 the first CLK edge that samples a new, stable SIGNAL value. FILTERED and the pulse become visible after edge SYNC_STAGES+FILTER_CYCLES (defaults: after edge 6).
- ENABLE low: the synchroniser and filter keep running, so FILTERED still tracks the input. Pulses and STATUS setting are suppressed. Raising ENABLE while FILTERED is stable produces no pulse.
- Changing ENABLE/RISE_EN/FALL_EN takes effect on the next update: the value sampled at the same edge as the FILTERED change is used.
- STATUS:
  - STATUS[i] sets on the edge where RISING_EDGE[i] or FALLING_EDGE[i] is registered high, so it is visible in the cycle after the pulse.
  - CLEAR[i] high clears STATUS[i] at the next edge.
  - Simultaneous set and clear: set wins, STATUS stays 1.
  - Held CLEAR keeps STATUS at 0 except on cycles with a new set.
- IRQ: combinational OR of registered STATUS, so it is glitch-free.
- Reset-release boundary: SIGNAL held high through reset release yields one rising pulse at the normal latency if enabled. This is intended; software clears it.
- Channels are fully independent; simultaneous events on different channels are all reported in the same cycle.

Test Plan:
- Reset: hold RESET 20 cycles, SIGNAL=8'hFF -> all outputs 0 during reset. After release, with ENABLE=RISE_EN=8'hFF: FILTERED=8'hFF and RISING_EDGE=8'hFF for exactly 1 cycle after edge 6.
- Basic edges on ch0, defaults: SIGNAL[0] 0->1, hold 10 cycles, then 1->0.
  - RISING_EDGE[0] is a 1-cycle pulse after edge 6; FALLING_EDGE[0] likewise after edge 6 of the fall.
  - STATUS[0]=1 and IRQ=1 from the cycle after the first pulse.
- Glitch filter: SIGNAL[1] high for 3 cycles (<FILTER_CYCLES=4) -> FILTERED[1], RISING_EDGE[1] and STATUS[1] stay 0. A 4-cycle stable high -> one pulse.
- Direction/enable gating:
  - RISE_EN[2]=0, FALL_EN[2]=1, toggle SIGNAL[2] -> only a falling pulse.
  - ENABLE[3]=0 while toggling, then set ENABLE[3]=1 with the input stable -> no pulse; FILTERED[3] still follows the input.
- Sticky clear: CLEAR[0] asserted on the same edge a new rising pulse on ch0 sets STATUS -> STATUS[0] stays 1. CLEAR[0] on a quiet cycle -> STATUS[0]=0; IRQ=0 when all STATUS=0.
- Reset mid-filter: SIGNAL[4] rises, RESET asserted 2 cycles later for 1 cycle -> no pulse from the aborted count. The edge is then re-detected at full latency measured from reset release.
